// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux channel multiplexer.
package arb_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel-index width; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational round-robin search: first requester after ptr, wrapping around.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned SW  = idx_w(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [SW-1:0]  gnt_idx,
    output logic           gnt_any
);

    logic [SW-1:0] ch;

    // Offset 1 first so the last winner gets lowest priority; offset NCH re-grants ptr itself.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        ch      = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            ch = SW'((32'(ptr) + k) % NCH);
            if (!gnt_any && req[ch]) begin
                gnt[ch] = 1'b1;
                gnt_idx = ch;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel valid/ready multiplexer with fixed or round-robin selection
// feeding a single registered output stage.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 8,
    parameter int unsigned SW  = idx_w(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SW-1:0]     out_chan
);

    logic [SW-1:0]  ptr_q, ptr_d;
    logic [DW-1:0]  data_q, data_d;
    logic [SW-1:0]  chan_q, chan_d;
    logic           valid_q, valid_d;

    logic [NCH-1:0] rr_gnt;
    logic [SW-1:0]  rr_idx;
    logic           rr_any;

    logic [NCH-1:0] cand_oh;
    logic [SW-1:0]  cand_idx;
    logic           cand_any;
    logic           load_c;
    logic           fire_c;

    rr_arbiter #(
        .NCH (NCH),
        .SW  (SW)
    ) u_rr (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // Candidate selection; an out-of-range or idle sel yields no grant.
    always_comb begin
        cand_oh  = '0;
        cand_idx = '0;
        cand_any = 1'b0;
        if (mode == MODE_RR) begin
            cand_oh  = rr_gnt;
            cand_idx = rr_idx;
            cand_any = rr_any;
        end else if (32'(sel) < NCH) begin
            cand_oh[sel] = in_valid[sel];
            cand_idx     = sel;
            cand_any     = in_valid[sel];
        end
    end

    assign load_c   = !valid_q || out_ready;
    assign fire_c   = rst_n && load_c && cand_any;
    assign in_ready = (rst_n && load_c) ? cand_oh : '0;

    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        if (load_c) begin
            valid_d = fire_c;
            if (fire_c) begin
                data_d = in_data[32'(cand_idx)*DW +: DW];
                chan_d = cand_idx;
            end
        end
        if (fire_c && mode == MODE_RR) begin
            ptr_d = cand_idx;
        end
    end

    // Reset parks ptr on the last channel so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= SW'(NCH - 1);
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter NCH, default 4, number of input channels, legal range 2..16.
REQ-002 Parameter DW, default 8, data width per channel in bits, minimum 1.
REQ-003 Parameter SW, default clog2(NCH), select and channel-index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  NCH*DW  channel i data occupies bits [i*DW +: DW].
REQ-007 in_valid  input  NCH  per-channel valid.
REQ-008 in_ready  output  NCH  per-channel ready, combinational; at most one bit high per cycle.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 sel  input  SW  selected channel in fixed mode; ignored in round-robin mode.
REQ-011 out_data  output  DW  registered output data.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_ready  input  1  downstream ready.
REQ-014 out_chan  output  SW  registered index of the channel that sourced out_data.

Function
REQ-015 A single output register stage holds exactly one word; "load" = !out_valid | out_ready.
REQ-016 Fixed mode: candidate = sel when sel < NCH and in_valid[sel]=1; otherwise no grant.
REQ-017 Round-robin mode: candidate = first channel with in_valid set, searching from (ptr+1) mod NCH upward with wrap.
REQ-018 in_ready[candidate] = load; all other in_ready bits = 0; transfer occurs when in_valid & in_ready are both high on a channel.
REQ-019 On a transfer, the next edge loads out_data, out_chan and sets out_valid=1; latency is exactly 1 cycle.
REQ-020 When load=1 and no transfer occurs, out_valid clears on the next edge if out_ready was 1.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_chan and out_valid hold stable.
REQ-022 Simultaneous drain and load in the same cycle sustains 1 word/cycle throughput with no bubble.
REQ-023 ptr updates to the granted channel only on a transfer in round-robin mode; ptr holds in fixed mode and on idle cycles.
REQ-024 Changes to mode or sel take effect on the same-cycle combinational grant, never on the word already held.
REQ-025 in_valid bits may change without handshake; a channel never receives in_ready without being the candidate.

Reset
REQ-026 Asserting rst_n low forces out_valid=0, out_data=0 and out_chan=0 immediately, regardless of clk.
REQ-027 Reset sets ptr=NCH-1, so channel 0 has first round-robin priority.
REQ-028 Reset mid-operation discards the held word, with no replay.
REQ-029 in_ready is 0 while rst_n is low.
REQ-030 Release of rst_n is synchronous to clk; the first transfer is possible on the first edge after release.

Structure
REQ-031 Package arb_mux_pkg holds MODE_FIXED=0, MODE_RR=1 and the clog2-based index width function.
REQ-032 Round-robin candidate search lives in sub-module rr_arbiter (inputs req[NCH] and ptr; output one-hot gnt and gnt_idx).
REQ-033 rr_arbiter is purely combinational.
REQ-034 The ptr register and the output register reside in arb_mux.
REQ-035 Implementation target: 120-400 lines of RTL total.

Verification
REQ-036 Fixed mode, NCH=4, DW=8, sel=2, in_data ch2=0xA5, in_valid=4'b0100, out_ready=1 -> next cycle out_data=0xA5, out_chan=2, out_valid=1.
REQ-037 Round-robin after reset, in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
REQ-038 out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_chan stable and in_ready=0 throughout; on out_ready=1, a new word loads the following cycle.
REQ-039 Round-robin, ptr=3, in_valid=4'b1000 only -> channel 3 re-granted (wrap search); ptr stays 3.
REQ-040 Fixed mode, sel=1 with in_valid[1]=0 and in_valid[0]=1 -> in_ready=0 on all channels, out_valid drops after the drain.
REQ-041 rst_n pulsed low between clock edges while out_valid=1 -> out_valid=0 immediately; after release, round-robin restarts at channel 0.
